// File: rtl/cpu_mem_pkg.sv
// Shared types for the IF/MEM memory path: response owner and arbitration winner.
// No logic, types and default widths only.
// Not applicable (no flow control in a package).
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_IF   = 2'd1,
    WIN_D    = 2'd2
  } win_t;

endpackage

// File: rtl/arb_pick.sv
// Picks the memory winner between fetch and data; STARVE_GUARD_EN adds fetch promotion.
// Latency: combinational decision, the starvation counter updates on the clock edge.
// Backpressure: a loser simply sees no grant and holds its request.
module arb_pick
  import cpu_mem_pkg::*;
`ifdef STARVE_GUARD_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
`ifdef STARVE_GUARD_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic if_req,
  input  logic d_req,
  output win_t win
);

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             promote;

  assign promote = (starve_cnt == CNT_MAX);

  always_comb begin
    win = WIN_NONE;
    if (if_req && (!d_req || promote)) begin
      win = WIN_IF;
    end else if (d_req) begin
      win = WIN_D;
    end
  end

  // Counts consecutive cycles a live fetch request went unserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || (win == WIN_IF)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    win = WIN_NONE;
    if (d_req) begin
      win = WIN_D;
    end else if (if_req) begin
      win = WIN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one sync-read memory between IF and MEM stages; STARVE_GUARD_EN enables fetch promotion.
// Latency: grant same cycle, read data exactly one cycle after grant, one access per cycle.
// Backpressure: requesters hold req until gnt; responses cannot be stalled.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1) begin : g_cfg_check
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  win_t   win;
  owner_t owner;
  owner_t owner_nxt;

`ifdef STARVE_GUARD_EN
  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req),
    .d_req  (d_req),
    .win    (win)
  );
`else
  arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .win    (win)
  );
`endif

  assign if_gnt = (win == WIN_IF);
  assign d_gnt  = (win == WIN_D);

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_nxt = OWN_NONE;
    case (win)
      WIN_IF: begin
        mem_ce    = 1'b1;
        mem_addr  = if_addr;
        owner_nxt = OWN_IF;
      end
      WIN_D: begin
        mem_ce    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        // Writes finish in the grant cycle, so they own no response slot.
        owner_nxt = d_we ? OWN_NONE : OWN_DRD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    case (owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_DRD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
